time_setter: RTL and testbench

User time-entry controller for the digital clock: turns five raw push-buttons into the clock's load interface. Debounces the buttons and walks hour, minute and second fields with wrap-around increment and decrement. On completion it presents `hour`/`min`/`sec` with a one-cycle `time_c` or `alm_c` strobe. It sits between the board buttons and the `clock` top, driving that module's `sec`, `min`, `hour`, `time_c` and `alm_c` inputs.

---
 rtl/clock_pkg.sv | 43 ++++
 rtl/btn_debounce.sv | 49 ++++
 rtl/time_setter.sv | 149 ++++++++++++++
 tb/tb_time_setter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared types and constants for the digital clock time-entry path.
package clock_pkg;

    localparam int unsigned TW = 6;

    localparam logic [TW-1:0] HOUR_MAX   = 6'd23;
    localparam logic [TW-1:0] MINSEC_MAX = 6'd59;

    localparam logic [1:0] FLD_NONE = 2'd0;
    localparam logic [1:0] FLD_HOUR = 2'd1;
    localparam logic [1:0] FLD_MIN  = 2'd2;
    localparam logic [1:0] FLD_SEC  = 2'd3;

    localparam int unsigned NBTN     = 5;
    localparam int unsigned BTN_TIME = 0;
    localparam int unsigned BTN_ALM  = 1;
    localparam int unsigned BTN_SEL  = 2;
    localparam int unsigned BTN_INC  = 3;
    localparam int unsigned BTN_DEC  = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_HOUR,
        ST_SET_MIN,
        ST_SET_SEC,
        ST_COMMIT
    } state_t;

    // Wrap-around step; simultaneous up and down cancel out.
    function automatic logic [TW-1:0] wrap_step(input logic [TW-1:0] val,
                                                input logic [TW-1:0] max,
                                                input logic          up,
                                                input logic          dn);
        logic [TW-1:0] res;
        res = val;
        if (up && !dn)
            res = (val == max) ? '0 : val + 1'b1;
        else if (dn && !up)
            res = (val == '0) ? max : val - 1'b1;
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw push-button: 2-flop synchronizer, debounce counter and a
// single-cycle pulse on each debounced press.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int unsigned   CW       = 16;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_pulse;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_pulse <= 1'b0;
            // Any sample agreeing with the current level restarts the run.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                    r_pulse <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_press = r_pulse;

endmodule

// File: rtl/time_setter.sv
// Button-driven hour/min/sec entry for the clock: debounced buttons walk the
// fields and a one-cycle time_c/alm_c strobe commits the edited value.
module time_setter
    import clock_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_time,
    input  logic          btn_alm,
    input  logic          btn_sel,
    input  logic          btn_inc,
    input  logic          btn_dec,
    output logic [TW-1:0] hour,
    output logic [TW-1:0] min,
    output logic [TW-1:0] sec,
    output logic          time_c,
    output logic          alm_c,
    output logic          editing,
    output logic [1:0]    field,
    output logic          target
);

    logic [NBTN-1:0] w_raw;
    logic [NBTN-1:0] w_press;

    assign w_raw = {btn_dec, btn_inc, btn_sel, btn_alm, btn_time};

    for (genvar g = 0; g < NBTN; g++) begin : g_deb
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk    (clk),
            .rst    (rst),
            .i_btn  (w_raw[g]),
            .o_press(w_press[g])
        );
    end

    logic w_p_time, w_p_alm, w_p_sel, w_p_inc, w_p_dec, w_abort;

    assign w_p_time = w_press[BTN_TIME];
    assign w_p_alm  = w_press[BTN_ALM];
    assign w_p_sel  = w_press[BTN_SEL];
    assign w_p_inc  = w_press[BTN_INC];
    assign w_p_dec  = w_press[BTN_DEC];
    assign w_abort  = w_p_time | w_p_alm;

    state_t        r_state, w_state_nx;
    logic [TW-1:0] r_hour, r_min, r_sec;
    logic [TW-1:0] w_hour_nx, w_min_nx, w_sec_nx;
    logic          r_target, w_target_nx;
    logic          r_editing, w_editing_nx;
    logic [1:0]    r_field, w_field_nx;
    logic          r_time_c, w_time_c_nx;
    logic          r_alm_c, w_alm_c_nx;

    always_comb begin
        w_state_nx  = r_state;
        w_hour_nx   = r_hour;
        w_min_nx    = r_min;
        w_sec_nx    = r_sec;
        w_target_nx = r_target;
        case (r_state)
            ST_IDLE: begin
                if (w_p_time) begin
                    w_state_nx  = ST_SET_HOUR;
                    w_target_nx = 1'b0;
                end else if (w_p_alm) begin
                    w_state_nx  = ST_SET_HOUR;
                    w_target_nx = 1'b1;
                end
            end
            ST_SET_HOUR: begin
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_hour_nx = wrap_step(r_hour, HOUR_MAX, w_p_inc, w_p_dec);
                    if (w_p_sel) w_state_nx = ST_SET_MIN;
                end
            end
            ST_SET_MIN: begin
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_min_nx = wrap_step(r_min, MINSEC_MAX, w_p_inc, w_p_dec);
                    if (w_p_sel) w_state_nx = ST_SET_SEC;
                end
            end
            ST_SET_SEC: begin
                if (w_abort) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_sec_nx = wrap_step(r_sec, MINSEC_MAX, w_p_inc, w_p_dec);
                    if (w_p_sel) w_state_nx = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nx = ST_IDLE;
            default:   w_state_nx = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they register together with it.
    always_comb begin
        w_editing_nx = 1'b0;
        w_field_nx   = FLD_NONE;
        case (w_state_nx)
            ST_SET_HOUR: begin w_editing_nx = 1'b1; w_field_nx = FLD_HOUR; end
            ST_SET_MIN:  begin w_editing_nx = 1'b1; w_field_nx = FLD_MIN;  end
            ST_SET_SEC:  begin w_editing_nx = 1'b1; w_field_nx = FLD_SEC;  end
            default:     begin w_editing_nx = 1'b0; w_field_nx = FLD_NONE; end
        endcase
        w_time_c_nx = (w_state_nx == ST_COMMIT) && !w_target_nx;
        w_alm_c_nx  = (w_state_nx == ST_COMMIT) &&  w_target_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_hour    <= '0;
            r_min     <= '0;
            r_sec     <= '0;
            r_target  <= 1'b0;
            r_editing <= 1'b0;
            r_field   <= FLD_NONE;
            r_time_c  <= 1'b0;
            r_alm_c   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_hour    <= w_hour_nx;
            r_min     <= w_min_nx;
            r_sec     <= w_sec_nx;
            r_target  <= w_target_nx;
            r_editing <= w_editing_nx;
            r_field   <= w_field_nx;
            r_time_c  <= w_time_c_nx;
            r_alm_c   <= w_alm_c_nx;
        end
    end

    assign hour    = r_hour;
    assign min     = r_min;
    assign sec     = r_sec;
    assign time_c  = r_time_c;
    assign alm_c   = r_alm_c;
    assign editing = r_editing;
    assign field   = r_field;
    assign target  = r_target;

endmodule

// File: tb/tb_time_setter.sv
// Self-checking bench for time_setter: table of button steps with expected
// status, plus a strobe scoreboard and hand-written debounce/reset sequences.
module tb_time_setter;

    localparam int unsigned DEB = 4;
    localparam logic [4:0] B_T = 5'd1, B_A = 5'd2, B_S = 5'd4, B_I = 5'd8, B_D = 5'd16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btns = '0;
    logic [5:0] hour, min, sec;
    logic       time_c, alm_c, editing, target;
    logic [1:0] field;

    time_setter #(.DEB_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_time(btns[0]),
        .btn_alm (btns[1]),
        .btn_sel (btns[2]),
        .btn_inc (btns[3]),
        .btn_dec (btns[4]),
        .hour    (hour),
        .min     (min),
        .sec     (sec),
        .time_c  (time_c),
        .alm_c   (alm_c),
        .editing (editing),
        .field   (field),
        .target  (target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] btn;
        logic       ed;
        logic [1:0] fld;
        logic       tgt;
        logic       tchk;
        logic [5:0] h, m, s;
        logic [1:0] cm;   // 0 none, 1 time commit, 2 alarm commit
    } vec_t;

    typedef struct {
        logic       tc, ac;
        logic [5:0] h, m, s;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input logic [4:0] b, input logic e, input logic [1:0] f,
                                input logic t, input logic tc, input logic [5:0] h,
                                input logic [5:0] m, input logic [5:0] s, input logic [1:0] c);
        vec_t v;
        v.btn = b; v.ed = e; v.fld = f; v.tgt = t; v.tchk = tc;
        v.h = h; v.m = m; v.s = s; v.cm = c;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e, input logic [1:0] f,
                           input logic t, input logic tc, input logic [5:0] h,
                           input logic [5:0] m, input logic [5:0] s);
        chk({tag, ".editing"}, int'(editing), int'(e));
        chk({tag, ".field"},   int'(field),   int'(f));
        if (tc) chk({tag, ".target"}, int'(target), int'(t));
        chk({tag, ".hour"},    int'(hour),    int'(h));
        chk({tag, ".min"},     int'(min),     int'(m));
        chk({tag, ".sec"},     int'(sec),     int'(s));
    endtask

    task automatic press(input logic [4:0] m);
        btns = m;
        repeat (8) @(negedge clk);
        btns = '0;
        repeat (8) @(negedge clk);
    endtask

    task automatic push_exp(input logic tc, input logic ac, input logic [5:0] h,
                            input logic [5:0] m, input logic [5:0] s);
        sb_t e;
        e.tc = tc; e.ac = ac; e.h = h; e.m = m; e.s = s;
        sbq.push_back(e);
    endtask

    initial begin
        vec_t v;
        bit   found;

        rst = 1'b1;
        btns = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        fork
            forever begin
                sb_t e;
                @(negedge clk);
                if (time_c || alm_c) begin
                    chk("strobe_exclusive", int'(time_c && alm_c), 0);
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_strobe: got time_c=%0b alm_c=%0b expected none", time_c, alm_c);
                    end else begin
                        e = sbq.pop_front();
                        chk("sb.time_c", int'(time_c), int'(e.tc));
                        chk("sb.alm_c",  int'(alm_c),  int'(e.ac));
                        chk("sb.hour",   int'(hour),   int'(e.h));
                        chk("sb.min",    int'(min),    int'(e.m));
                        chk("sb.sec",    int'(sec),    int'(e.s));
                    end
                end
            end
            begin
                repeat (20000) @(posedge clk);
                checks++;
                errors++;
                $display("FAIL watchdog: got 20000 cycles expected completion");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        join_none

        chk_out("reset", 0, 0, 0, 1, 0, 0, 0);
        chk("reset.time_c", int'(time_c), 0);
        chk("reset.alm_c", int'(alm_c), 0);
        repeat (20) @(negedge clk);
        chk_out("idle20", 0, 0, 0, 1, 0, 0, 0);

        // btn, ed, fld, tgt, tchk, hour, min, sec, commit
        tbl.push_back(mk(B_T,       1, 1, 0, 1,  0, 0,  0, 0));
        tbl.push_back(mk(B_I,       1, 1, 0, 1,  1, 0,  0, 0));
        tbl.push_back(mk(B_I,       1, 1, 0, 1,  2, 0,  0, 0));
        tbl.push_back(mk(B_I,       1, 1, 0, 1,  3, 0,  0, 0));
        tbl.push_back(mk(B_S,       1, 2, 0, 1,  3, 0,  0, 0));
        tbl.push_back(mk(B_D,       1, 2, 0, 1,  3, 59, 0, 0));
        tbl.push_back(mk(B_S,       1, 3, 0, 1,  3, 59, 0, 0));
        tbl.push_back(mk(B_I,       1, 3, 0, 1,  3, 59, 1, 0));
        tbl.push_back(mk(B_I,       1, 3, 0, 1,  3, 59, 2, 0));
        tbl.push_back(mk(B_S,       0, 0, 0, 0,  3, 59, 2, 1));
        tbl.push_back(mk(B_A,       1, 1, 1, 1,  3, 59, 2, 0));
        tbl.push_back(mk(B_D,       1, 1, 1, 1,  2, 59, 2, 0));
        tbl.push_back(mk(B_D,       1, 1, 1, 1,  1, 59, 2, 0));
        tbl.push_back(mk(B_D,       1, 1, 1, 1,  0, 59, 2, 0));
        tbl.push_back(mk(B_D,       1, 1, 1, 1, 23, 59, 2, 0));
        tbl.push_back(mk(B_I,       1, 1, 1, 1,  0, 59, 2, 0));
        tbl.push_back(mk(B_S,       1, 2, 1, 1,  0, 59, 2, 0));
        tbl.push_back(mk(B_S,       1, 3, 1, 1,  0, 59, 2, 0));
        tbl.push_back(mk(B_S,       0, 0, 0, 0,  0, 59, 2, 2));
        tbl.push_back(mk(B_I,       0, 0, 0, 0,  0, 59, 2, 0));
        tbl.push_back(mk(B_S,       0, 0, 0, 0,  0, 59, 2, 0));
        tbl.push_back(mk(B_T | B_A, 1, 1, 0, 1,  0, 59, 2, 0));
        tbl.push_back(mk(B_I | B_D, 1, 1, 0, 1,  0, 59, 2, 0));
        tbl.push_back(mk(B_I | B_S, 1, 2, 0, 1,  1, 59, 2, 0));
        tbl.push_back(mk(B_T | B_S, 0, 0, 0, 0,  1, 59, 2, 0));
        tbl.push_back(mk(B_A,       1, 1, 1, 1,  1, 59, 2, 0));
        tbl.push_back(mk(B_S,       1, 2, 1, 1,  1, 59, 2, 0));
        tbl.push_back(mk(B_A,       0, 0, 0, 0,  1, 59, 2, 0));
        tbl.push_back(mk(B_T,       1, 1, 0, 1,  1, 59, 2, 0));
        tbl.push_back(mk(B_S,       1, 2, 0, 1,  1, 59, 2, 0));
        tbl.push_back(mk(B_I,       1, 2, 0, 1,  1, 0,  2, 0));
        tbl.push_back(mk(B_D | B_S, 1, 3, 0, 1,  1, 59, 2, 0));
        tbl.push_back(mk(B_I,       1, 3, 0, 1,  1, 59, 3, 0));
        tbl.push_back(mk(B_I | B_S, 0, 0, 0, 0,  1, 59, 4, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.cm == 2'd1) push_exp(1'b1, 1'b0, v.h, v.m, v.s);
            if (v.cm == 2'd2) push_exp(1'b0, 1'b1, v.h, v.m, v.s);
            press(v.btn);
            chk_out($sformatf("vec%0d", i), v.ed, v.fld, v.tgt, v.tchk, v.h, v.m, v.s);
        end

        // Bounce shorter than the debounce window must never register.
        press(B_T);
        chk_out("bounce_entry", 1, 1, 0, 1, 1, 59, 4);
        for (int i = 0; i < 8; i++) begin
            btns = B_I;
            repeat (2) @(negedge clk);
            btns = '0;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("bounce.hour", int'(hour), 1);
        chk("bounce.field", int'(field), 1);

        // Clean hold: increment lands exactly DEB+3 edges after first sample.
        btns = B_I;
        repeat (DEB + 2) @(posedge clk);
        #1 chk("latency.before", int'(hour), 1);
        @(posedge clk);
        #1 chk("latency.at", int'(hour), 2);
        repeat (3) @(negedge clk);
        btns = '0;
        repeat (10) @(negedge clk);
        chk("hold.single_inc", int'(hour), 2);
        press(B_T);
        chk_out("bounce_abort", 0, 0, 0, 0, 2, 59, 4);

        // Reset landing on the COMMIT cycle.
        press(B_T);
        press(B_S);
        press(B_S);
        chk_out("pre_commit", 1, 3, 0, 1, 2, 59, 4);
        push_exp(1'b1, 1'b0, 6'd2, 6'd59, 6'd4);
        btns = B_S;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (time_c) found = 1'b1;
        end
        chk("commit_seen", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        btns = '0;
        chk_out("rst_commit", 0, 0, 0, 1, 0, 0, 0);
        chk("rst_commit.time_c", int'(time_c), 0);
        chk("rst_commit.alm_c", int'(alm_c), 0);
        repeat (20) @(negedge clk);
        chk_out("post_rst", 0, 0, 0, 1, 0, 0, 0);

        chk("sb_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
